wbm_burst_master: RTL
=====================

# wbm_burst_master

Parametrised Wishbone B4 pipelined burst master for the SPI subsystem. It turns one command (address, word count, direction, tags) into a single Wishbone cycle of back-to-back strobes, honouring stall and counting acks. It streams write data in and read data out, and terminates the cycle on completion, error or ack timeout. It sits between the host-side controller and the SPI master's Wishbone slave port.

## Interface
- data_width_g, 8, data word width
- blen_width_g, 9, burst length field width (burst = cmd_len+1 words, max 2^blen_width_g)
- addr_width_g, 10, address width
- addr_inc_g, 1, 1 = address increments per accepted strobe; 0 = fixed address (FIFO-style target)
- timeout_g, 255, max cycles without ack while acks are outstanding; 0 disables the watchdog
- clock  in  1  system clock
- rst  in  1  reset, asynchronous, active-low
- cmd_valid  in  1  command request
- cmd_ready  out  1  high only in IDLE
- cmd_we  in  1  1 = write burst, 0 = read burst
- cmd_adr  in  addr_width_g  start address
- cmd_len  in  blen_width_g  words minus one
- cmd_tgc, cmd_tgd  in  1 each  copied to wbm_tgc_o / wbm_tgd_o for the whole cycle
- wr_dat  in  data_width_g  write data
- wr_valid  in  1  write word available
- wr_ready  out  1  write word consumed this cycle
- rd_dat  out  data_width_g  read data
- rd_valid  out  1  one-cycle pulse per read word
- done  out  1  one-cycle pulse at burst end
- status  out  2  00 ok, 01 bus error, 10 timeout; held until next command accepted
- wbm_cyc_o, wbm_stb_o, wbm_we_o  out  1 each  Wishbone master controls
- wbm_adr_o  out  addr_width_g  address
- wbm_tga_o  out  blen_width_g  burst length tag (= cmd_len)
- wbm_dat_o  out  data_width_g  write data
- wbm_tgc_o, wbm_tgd_o  out  1 each  cycle tags
- wbm_dat_i  in  data_width_g  read data
- wbm_stall_i, wbm_ack_i, wbm_err_i  in  1 each  slave responses

## Operation
- States: IDLE, ISSUE, WAIT, FIN.
- IDLE: on cmd_valid, latch the command, clear counters and status, and set wbm_cyc_o, wbm_we_o, wbm_tga_o and the tags. Next state is ISSUE.
- Strobe acceptance: a strobe is accepted when wbm_stb_o && !wbm_stall_i. `issued` increments on each acceptance. wbm_adr_o advances by addr_inc_g on each acceptance.
- ISSUE, read burst:
  - wbm_stb_o stays high until issued reaches cmd_len+1.
  - Once the final strobe is accepted, the next state is WAIT.
- ISSUE, write burst:
  - A new word may load into wbm_dat_o when the strobe slot is free: (!wbm_stb_o || !wbm_stall_i), wr_valid is high, and loaded < cmd_len+1.
  - wr_ready = that same condition. On load, wbm_stb_o goes high next cycle.
  - When no word is available, wbm_stb_o drops; wbm_cyc_o stays high.
- Ack counting: `acked` increments on wbm_ack_i in ISSUE and WAIT. Acks are ignored when acked == issued.
- Completion: when acked reaches cmd_len+1, the next state is FIN with status 00.
- Read data: each ack in a read burst produces rd_valid the next cycle, with rd_dat = registered wbm_dat_i. There is no backpressure.
- Bus error: wbm_err_i in ISSUE or WAIT gives next state FIN with status 01. Err wins over a same-cycle ack (that ack is not counted).
- Watchdog: counts cycles since the last ack while acked < issued; it resets on every ack. When it reaches timeout_g, next state is FIN with status 10.
- FIN:
  - cyc and stb drop on entry, so FIN cycle outputs are cyc = stb = 0.
  - done pulses for that single cycle.
  - Next state is IDLE.
- Counters are blen_width_g+1 bits wide, so cmd_len = all-ones (2^blen_width_g words) does not wrap.

## Timing
- Reset (async assert, sync release): all outputs 0, including status 00. cmd_ready asserts the first cycle after release. Any cycle in flight is abandoned, with cyc dropping immediately.
- Command accept to first wbm_stb_o:
  - read: 1 cycle;
  - write: 1 cycle after the first wr_valid seen in ISSUE.
- With no stall, a read issues one strobe per cycle. An N-word read with 1-cycle ack latency gives done N+2 cycles after stb first rises.
- Stall holds wbm_stb_o, wbm_adr_o and wbm_dat_o stable.
- cmd_ready is low from accept until the cycle after FIN.

## Test plan
- Read, len=3 (4 words), adr=0x010, no stall, ack 1 cycle after each strobe:
  - adr sequence 0x010..0x013, tga=3;
  - 4 rd_valid pulses carrying 0xA0..0xA3;
  - done with status 00; cyc low in the FIN cycle.
- Write, len=1, stall on the first strobe for 2 cycles:
  - wbm_dat_o and adr held during the stall; wr_ready pulses exactly twice;
  - done with status 00.
- Write with wr_valid gaps (words present every 3rd cycle): stb drops between words, cyc stays high, and 3 acks complete the burst.
- addr_inc_g=0, len=7: adr stays constant at cmd_adr for all 8 strobes.
- Error: wbm_err_i together with the 2nd ack of a len=3 read: acked=1, next cycle FIN, status 01, cyc low, one done pulse.
- Timeout with timeout_g=4: ack withheld after the 1st strobe, giving status 10 after 4 idle cycles. Separately, async reset asserted mid-burst: all outputs 0 at once.

Source files
------------

// File: rtl/wbm_burst_master_if.sv
// Wishbone B4 pipelined bus bundle between the burst master and its slave.
// The master drives cycle, strobe, address, data and tags; the slave responds.
interface wbm_burst_master_if #(
  parameter int data_width_g = 8,
  parameter int blen_width_g = 9,
  parameter int addr_width_g = 10
);
  logic                    wbm_cyc_o;
  logic                    wbm_stb_o;
  logic                    wbm_we_o;
  logic [addr_width_g-1:0] wbm_adr_o;
  logic [blen_width_g-1:0] wbm_tga_o;
  logic [data_width_g-1:0] wbm_dat_o;
  logic                    wbm_tgc_o;
  logic                    wbm_tgd_o;
  logic [data_width_g-1:0] wbm_dat_i;
  logic                    wbm_stall_i;
  logic                    wbm_ack_i;
  logic                    wbm_err_i;

  modport master (
    output wbm_cyc_o, wbm_stb_o, wbm_we_o,
    output wbm_adr_o, wbm_tga_o, wbm_dat_o,
    output wbm_tgc_o, wbm_tgd_o,
    input  wbm_dat_i, wbm_stall_i,
    input  wbm_ack_i, wbm_err_i
  );

  modport slave (
    input  wbm_cyc_o, wbm_stb_o, wbm_we_o,
    input  wbm_adr_o, wbm_tga_o, wbm_dat_o,
    input  wbm_tgc_o, wbm_tgd_o,
    output wbm_dat_i, wbm_stall_i,
    output wbm_ack_i, wbm_err_i
  );
endinterface

// File: rtl/wbm_burst_master.sv
// Wishbone B4 pipelined burst master: one command becomes one bus cycle
// of back-to-back strobes, closed on completion, bus error or ack timeout.
module wbm_burst_master #(
  parameter int data_width_g = 8,
  parameter int blen_width_g = 9,
  parameter int addr_width_g = 10,
  parameter int addr_inc_g   = 1,
  parameter int timeout_g    = 255
) (
  input  logic                    clock,
  input  logic                    rst,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_we,
  input  logic [addr_width_g-1:0] cmd_adr,
  input  logic [blen_width_g-1:0] cmd_len,
  input  logic                    cmd_tgc,
  input  logic                    cmd_tgd,
  input  logic [data_width_g-1:0] wr_dat,
  input  logic                    wr_valid,
  output logic                    wr_ready,
  output logic [data_width_g-1:0] rd_dat,
  output logic                    rd_valid,
  output logic                    done,
  output logic [1:0]              status,
  wbm_burst_master_if.master      wb
);

  localparam int cnt_w = blen_width_g + 1;
  localparam int wd_w  =
    (timeout_g > 1) ? $clog2(timeout_g + 1) : 1;
  localparam logic [wd_w-1:0] wd_lim =
    wd_w'(timeout_g);
  localparam logic [addr_width_g-1:0] adr_step =
    addr_width_g'(addr_inc_g != 0);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    FIN
  } state_t;

  state_t state;
  state_t state_n;

  logic             we_r;
  logic [cnt_w-1:0] total;
  logic [cnt_w-1:0] issued;
  logic [cnt_w-1:0] issued_n;
  logic [cnt_w-1:0] acked;
  logic [cnt_w-1:0] loaded;
  logic [wd_w-1:0]  wd;
  logic [1:0]       status_n;
  logic             active;
  logic             acc;
  logic             ack_cnt;
  logic             ld;
  logic             wd_hit;

  assign active = (state == ISSUE) || (state == WAIT);
  assign acc    = wb.wbm_stb_o && !wb.wbm_stall_i;

  // A duplicate or late ack after all strobes are acked is dropped.
  assign ack_cnt = active && wb.wbm_ack_i &&
                   !wb.wbm_err_i && (acked != issued);

  assign ld = (state == ISSUE) && we_r &&
              (!wb.wbm_stb_o || !wb.wbm_stall_i) &&
              wr_valid && (loaded < total);

  assign issued_n = issued + cnt_w'(acc);
  assign wd_hit   = (timeout_g != 0) && (wd == wd_lim);
  assign wr_ready = ld;
  assign done     = (state == FIN);

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_n;
  end

  always_comb begin
    state_n  = state;
    status_n = status;
    unique case (state)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          state_n  = ISSUE;
          status_n = 2'b00;
        end
      end
      ISSUE, WAIT: begin
        if (wb.wbm_err_i) begin
          state_n  = FIN;
          status_n = 2'b01;
        end else if (acked == total) begin
          state_n  = FIN;
          status_n = 2'b00;
        end else if (wd_hit) begin
          state_n  = FIN;
          status_n = 2'b10;
        end else if (state == ISSUE &&
                     issued_n == total) begin
          state_n = WAIT;
        end
      end
      FIN:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      cmd_ready    <= 1'b0;
      status       <= 2'b00;
      rd_valid     <= 1'b0;
      rd_dat       <= '0;
      we_r         <= 1'b0;
      total        <= '0;
      issued       <= '0;
      acked        <= '0;
      loaded       <= '0;
      wd           <= '0;
      wb.wbm_cyc_o <= 1'b0;
      wb.wbm_stb_o <= 1'b0;
      wb.wbm_we_o  <= 1'b0;
      wb.wbm_adr_o <= '0;
      wb.wbm_tga_o <= '0;
      wb.wbm_dat_o <= '0;
      wb.wbm_tgc_o <= 1'b0;
      wb.wbm_tgd_o <= 1'b0;
    end else begin
      cmd_ready <= (state_n == IDLE);
      status    <= status_n;
      rd_valid  <= ack_cnt && !we_r;
      if (ack_cnt && !we_r) rd_dat <= wb.wbm_dat_i;

      if (state == IDLE && state_n == ISSUE) begin
        we_r         <= cmd_we;
        total        <= {1'b0, cmd_len} + cnt_w'(1);
        issued       <= '0;
        acked        <= '0;
        loaded       <= '0;
        wd           <= '0;
        wb.wbm_cyc_o <= 1'b1;
        wb.wbm_stb_o <= 1'b0;
        wb.wbm_we_o  <= cmd_we;
        wb.wbm_adr_o <= cmd_adr;
        wb.wbm_tga_o <= cmd_len;
        wb.wbm_tgc_o <= cmd_tgc;
        wb.wbm_tgd_o <= cmd_tgd;
      end else if (active) begin
        if (acc) begin
          issued       <= issued_n;
          wb.wbm_adr_o <= wb.wbm_adr_o + adr_step;
        end
        if (ack_cnt) acked <= acked + cnt_w'(1);

        // Watchdog only runs while strobes await their acks.
        if (ack_cnt || acked == issued) wd <= '0;
        else if (!wd_hit)               wd <= wd + wd_w'(1);

        if (ld) begin
          wb.wbm_dat_o <= wr_dat;
          loaded       <= loaded + cnt_w'(1);
        end

        if (state_n == FIN) begin
          wb.wbm_cyc_o <= 1'b0;
          wb.wbm_stb_o <= 1'b0;
        end else if (we_r) begin
          wb.wbm_stb_o <= ld || (wb.wbm_stb_o && !acc);
        end else begin
          wb.wbm_stb_o <= (issued_n < total);
        end
      end
    end
  end

endmodule
